// File: rtl/spmv_sequencer.sv
// spmv_sequencer
// Control sequencer for one CSR sparse-matrix x dense-vector product
// (y = A*x) over a shared word-addressed memory. Each non-zero costs
// three reads (colidx, val, x) and one multiply-accumulate on the FPU.
// Each row ends with one write of the accumulated result to y.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   start, abort                job request (IDLE only) / synchronous abort
//   n_rows, *_base              job configuration, latched with start
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_rdata
//                               memory port, read data one cycle after mem_ren
//   fpu_start/fpu_a/fpu_b/fpu_c/fpu_result/fpu_done
//                               MAC unit port, computes a*b+c
//   busy, done, err             status: not-idle, completion pulse, sticky error
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// RD_PTR0   | reading rowptr[row]
// RD_PTR1   | capturing k, reading rowptr[row+1]
// CHK_ROW   | capturing k_end, checking row extent
// RD_COL    | reading colidx[k]
// RD_VAL    | reading val[k] (colidx[k] on mem_rdata)
// RD_X      | reading x[col] (val[k] on mem_rdata)
// MAC_ISSUE | fpu_start pulse (x[col] on mem_rdata drives fpu_b)
// MAC_WAIT  | waiting for fpu_done with timeout
// WR_Y      | writing acc to y[row]
// DONE      | done pulse

module spmv_sequencer #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int FPU_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] n_rows,
   input  logic [ADDR_W-1:0] rowptr_base,
   input  logic [ADDR_W-1:0] colidx_base,
   input  logic [ADDR_W-1:0] val_base,
   input  logic [ADDR_W-1:0] x_base,
   input  logic [ADDR_W-1:0] y_base,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fpu_start,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   output logic [DATA_W-1:0] fpu_c,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic              fpu_done,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int TW = $clog2(FPU_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
   localparam logic [DATA_W-1:0] ONE_D  = DATA_W'(1);
   localparam logic [TW-1:0]     ONE_T  = TW'(1);
   localparam logic [TW-1:0]     TC_LOAD = TW'(FPU_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_PTR0, S_RD_PTR1, S_CHK_ROW, S_RD_COL, S_RD_VAL,
      S_RD_X, S_MAC_ISSUE, S_MAC_WAIT, S_WR_Y, S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] n_rows_q;
   logic [ADDR_W-1:0] rowptr_q, colidx_q, val_q, x_q, y_q;
   logic [DATA_W-1:0] k, k_end;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] b_q;
   logic [TW-1:0]     tcnt;

   // x[col] is only on mem_rdata during MAC_ISSUE, so fpu_b bypasses it
   // there and holds the captured copy afterwards.
   assign fpu_b = (state == S_MAC_ISSUE) ? mem_rdata : b_q;
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         row       <= '0;
         n_rows_q  <= '0;
         rowptr_q  <= '0;
         colidx_q  <= '0;
         val_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         k         <= '0;
         k_end     <= '0;
         acc       <= '0;
         b_q       <= '0;
         tcnt      <= '0;
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         fpu_start <= 1'b0;
         fpu_a     <= '0;
         fpu_c     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Strobes and done are single-cycle unless re-armed below.
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         fpu_start <= 1'b0;
         done      <= 1'b0;

         if (state != S_IDLE && abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     n_rows_q <= n_rows;
                     rowptr_q <= rowptr_base;
                     colidx_q <= colidx_base;
                     val_q    <= val_base;
                     x_q      <= x_base;
                     y_q      <= y_base;
                     err      <= 1'b0;
                     row      <= '0;
                     if (n_rows == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state    <= S_RD_PTR0;
                        mem_ren  <= 1'b1;
                        mem_addr <= rowptr_base;
                     end
                  end
               end
               S_RD_PTR0: begin
                  state    <= S_RD_PTR1;
                  mem_ren  <= 1'b1;
                  mem_addr <= rowptr_q + row + ONE_A;
               end
               S_RD_PTR1: begin
                  k     <= mem_rdata;
                  state <= S_CHK_ROW;
               end
               S_CHK_ROW: begin
                  k_end <= mem_rdata;
                  acc   <= '0;
                  if (mem_rdata < k) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else if (mem_rdata == k) begin
                     state     <= S_WR_Y;
                     mem_wen   <= 1'b1;
                     mem_addr  <= y_q + row;
                     mem_wdata <= '0;
                  end else begin
                     state    <= S_RD_COL;
                     mem_ren  <= 1'b1;
                     mem_addr <= colidx_q + k[ADDR_W-1:0];
                  end
               end
               S_RD_COL: begin
                  state    <= S_RD_VAL;
                  mem_ren  <= 1'b1;
                  mem_addr <= val_q + k[ADDR_W-1:0];
               end
               S_RD_VAL: begin
                  // colidx[k] is on mem_rdata now; use it directly as col.
                  state    <= S_RD_X;
                  mem_ren  <= 1'b1;
                  mem_addr <= x_q + mem_rdata[ADDR_W-1:0];
               end
               S_RD_X: begin
                  state     <= S_MAC_ISSUE;
                  fpu_start <= 1'b1;
                  fpu_a     <= mem_rdata;
                  fpu_c     <= acc;
               end
               S_MAC_ISSUE: begin
                  state <= S_MAC_WAIT;
                  b_q   <= mem_rdata;
                  tcnt  <= TC_LOAD;
               end
               S_MAC_WAIT: begin
                  // A completion in the last allowed cycle still counts.
                  if (fpu_done) begin
                     acc <= fpu_result;
                     k   <= k + ONE_D;
                     if (k + ONE_D < k_end) begin
                        state    <= S_RD_COL;
                        mem_ren  <= 1'b1;
                        mem_addr <= colidx_q + k[ADDR_W-1:0] + ONE_A;
                     end else begin
                        state     <= S_WR_Y;
                        mem_wen   <= 1'b1;
                        mem_addr  <= y_q + row;
                        mem_wdata <= fpu_result;
                     end
                  end else if (tcnt == '0) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     tcnt <= tcnt - ONE_T;
                  end
               end
               S_WR_Y: begin
                  row <= row + ONE_A;
                  if (row + ONE_A == n_rows_q) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_RD_PTR0;
                     mem_ren  <= 1'b1;
                     mem_addr <= rowptr_q + row + ONE_A;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
